// File: rtl/mips_pkg.sv
// Shared fetch-stage types and defaults.
// Imported by instr_fetch, its interface and pc_next_calc.
package mips_pkg;

  localparam int          DEF_WL       = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_BYTES  = 4;

  typedef enum logic {
    FETCH,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: imem req/ack bus, decode valid/ready
// and the redirect fields fed back from decode.
interface instr_fetch_if
  import mips_pkg::*;
#(
  parameter int WL = DEF_WL
);

  logic          imem_req;
  logic [WL-1:0] imem_addr;
  logic          imem_ack;
  logic [WL-1:0] imem_rdata;

  logic [WL-1:0] Instr;
  logic [WL-1:0] Instr_pc;
  logic          Instr_valid;
  logic          Instr_ready;

  logic          branch_taken;
  logic [15:0]   Imm;
  logic          jump_en;
  logic [25:0]   jumpt;
  logic          jr_en;
  logic [WL-1:0] jr_addr;

  modport master (
    output imem_req, imem_addr,
    output Instr, Instr_pc, Instr_valid,
    input  imem_ack, imem_rdata, Instr_ready,
    input  branch_taken, Imm, jump_en,
    input  jumpt, jr_en, jr_addr
  );

  modport slave (
    input  imem_req, imem_addr,
    input  Instr, Instr_pc, Instr_valid,
    output imem_ack, imem_rdata, Instr_ready,
    output branch_taken, Imm, jump_en,
    output jumpt, jr_en, jr_addr
  );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the fetch stage.
// Priority: jr > jump > branch > sequential.
module pc_next_calc
  import mips_pkg::*;
#(
  parameter int WL = DEF_WL
) (
  input  logic [WL-1:0] Instr_pc,
  input  logic [15:0]   Imm,
  input  logic [25:0]   jumpt,
  input  logic [WL-1:0] jr_addr,
  input  logic          branch_taken,
  input  logic          jump_en,
  input  logic          jr_en,
  output logic [WL-1:0] next_pc,
  output logic [WL-1:0] seq_pc
);

  logic [WL-1:0] br_off;

  assign seq_pc = Instr_pc + WL'(INSTR_BYTES);
  // sign-extend then word-scale
  assign br_off = {{(WL-18){Imm[15]}}, Imm, 2'b00};

  always_comb begin
    next_pc = seq_pc;
    priority case (1'b1)
      jr_en:
        next_pc = jr_addr & ~WL'(3);
      jump_en:
        next_pc = {seq_pc[WL-1:WL-4], jumpt, 2'b00};
      branch_taken:
        next_pc = seq_pc + br_off;
      default:
        next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns PC, fetches over imem req/ack, hands Instr to decode.
// Optional BRANCH_DELAY_SLOT_EN delivers one delay slot after a redirect.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int            WL       = DEF_WL,
  parameter logic [WL-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  instr_fetch_if.master   f
);

  fetch_state_t  state;
  logic [WL-1:0] pc;
  logic [WL-1:0] next_pc;
  logic [WL-1:0] seq_pc;
  logic [WL-1:0] fetch_pc;
  logic          redirect;
  logic          fire;

  assign fire     = f.Instr_valid & f.Instr_ready;
  assign redirect = f.jr_en | f.jump_en | f.branch_taken;

  pc_next_calc #(.WL(WL)) u_calc (
    .Instr_pc     (f.Instr_pc),
    .Imm          (f.Imm),
    .jumpt        (f.jumpt),
    .jr_addr      (f.jr_addr),
    .branch_taken (f.branch_taken),
    .jump_en      (f.jump_en),
    .jr_en        (f.jr_en),
    .next_pc      (next_pc),
    .seq_pc       (seq_pc)
  );

`ifdef BRANCH_DELAY_SLOT_EN
  logic          pending;
  logic [WL-1:0] pending_target;

  // delay slot first; a pending target beats any new redirect
  assign fetch_pc = pending ? pending_target : seq_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending        <= 1'b0;
      pending_target <= '0;
    end else if (fire) begin
      if (pending) begin
        pending <= 1'b0;
      end else if (redirect) begin
        pending        <= 1'b1;
        pending_target <= next_pc;
      end
    end
  end
`else
  assign fetch_pc = redirect ? next_pc : seq_pc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      f.imem_req    <= 1'b0;
      f.imem_addr   <= '0;
      f.Instr       <= '0;
      f.Instr_pc    <= '0;
      f.Instr_valid <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (!f.imem_req) begin
            f.imem_req  <= 1'b1;
            f.imem_addr <= pc;
          end else if (f.imem_ack) begin
            f.imem_req    <= 1'b0;
            f.Instr       <= f.imem_rdata;
            f.Instr_pc    <= pc;
            f.Instr_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          // issue the next request on the consume edge
          if (fire) begin
            f.Instr_valid <= 1'b0;
            pc            <= fetch_pc;
            f.imem_req    <= 1'b1;
            f.imem_addr   <= fetch_pc;
            state         <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
